// File: rtl/spi_ep_router.sv
// SPI endpoint router: decodes spi_csel into a one-hot endpoint, frames start/stop,
// forwards rx bytes and prefetches the selected endpoint's next tx byte.
module spi_ep_router #(
  parameter int          NUM_EP    = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            spi_csel,
  input  logic                  fe_rx_valid,
  input  logic [7:0]            fe_rx_data,
  input  logic                  fe_tx_load,
  output logic [7:0]            fe_tx_data,
  output logic [NUM_EP-1:0]     ep_sel,
  output logic [NUM_EP-1:0]     ep_start,
  output logic [NUM_EP-1:0]     ep_stop,
  output logic [NUM_EP-1:0]     ep_rx_valid,
  output logic [7:0]            ep_rx_data,
  input  logic [NUM_EP-1:0]     ep_tx_valid,
  input  logic [8*NUM_EP-1:0]   ep_tx_data,
  output logic [NUM_EP-1:0]     ep_tx_ready,
  output logic                  busy,
  output logic [7:0]            underrun_cnt,
  output logic [7:0]            drop_cnt
);

  localparam logic [7:0] MAX_SEL = 8'(NUM_EP);

  typedef enum logic [1:0] {IDLE, START, ACTIVE, STOP} state_t;

  state_t            state, state_nxt;
  logic [7:0]        sel_q;
  logic [NUM_EP-1:0] sel_oh;
  logic [NUM_EP-1:0] csel_oh;
  logic [7:0]        csel_idx;
  logic              hold_valid;
  logic [7:0]        hold;
  logic              ep_ok;
  logic              pop;
  logic              open_sel;
  logic [7:0]        tx_byte;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Range check on the full 8-bit select before forming the endpoint index
  always_comb begin
    csel_oh  = '0;
    csel_idx = spi_csel - 8'd1;
    if (spi_csel != 8'd0 && spi_csel <= MAX_SEL) begin
      for (int i = 0; i < NUM_EP; i++) csel_oh[i] = (csel_idx == 8'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (spi_csel != 8'd0) state_nxt = START;
      START:   state_nxt = ACTIVE;
      ACTIVE:  if (spi_csel != sel_q) state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign open_sel = (state == IDLE) && (state_nxt == START);
  assign ep_ok    = (state == ACTIVE) && (|sel_oh);
  assign pop      = ep_ok && !hold_valid && (|(ep_tx_valid & sel_oh));
  assign ep_tx_ready = (ep_ok && !hold_valid) ? (ep_tx_valid & sel_oh) : '0;
  assign fe_tx_data  = hold_valid ? hold : IDLE_BYTE;
  assign busy        = (state != IDLE);

  always_comb begin
    tx_byte = IDLE_BYTE;
    for (int i = 0; i < NUM_EP; i++) begin
      if (sel_oh[i]) tx_byte = ep_tx_data[8*i +: 8];
    end
  end

  // Selection latch and endpoint framing strobes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q    <= 8'd0;
      sel_oh   <= '0;
      ep_sel   <= '0;
      ep_start <= '0;
      ep_stop  <= '0;
    end else begin
      if (open_sel) begin
        sel_q  <= spi_csel;
        sel_oh <= csel_oh;
      end
      ep_start <= open_sel ? csel_oh : '0;
      ep_stop  <= (state_nxt == STOP) ? sel_oh : '0;
      case (state_nxt)
        START:   ep_sel <= csel_oh;
        ACTIVE:  ep_sel <= sel_oh;
        default: ep_sel <= '0;
      endcase
    end
  end

  // Receive forwarding and drop/underrun accounting
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ep_rx_valid  <= '0;
      ep_rx_data   <= 8'd0;
      drop_cnt     <= 8'd0;
      underrun_cnt <= 8'd0;
    end else begin
      ep_rx_valid <= (fe_rx_valid && ep_ok) ? sel_oh : '0;
      if (fe_rx_valid && ep_ok)  ep_rx_data <= fe_rx_data;
      if (fe_rx_valid && !ep_ok) drop_cnt <= sat_inc(drop_cnt);
      if (fe_tx_load && ep_ok && !hold_valid) underrun_cnt <= sat_inc(underrun_cnt);
    end
  end

  // Holding register: anything left when leaving ACTIVE is discarded
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
    end else if (state_nxt != ACTIVE) begin
      hold_valid <= 1'b0;
    end else if (pop) begin
      hold_valid <= 1'b1;
    end else if (fe_tx_load) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) hold <= tx_byte;
  end

endmodule

// File: tb/tb_spi_ep_router.sv
// Randomized scoreboard bench for spi_ep_router with a transaction-level reference model.
module tb_spi_ep_router;

  localparam int NEP  = 4;
  localparam int MEMN = 2048;
  localparam logic [7:0] IDLE_B = 8'h00;
  localparam int M_IDLE = 0, M_START = 1, M_ACT = 2, M_STOP = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic [7:0]        spi_csel;
  logic              fe_rx_valid;
  logic [7:0]        fe_rx_data;
  logic              fe_tx_load;
  logic [7:0]        fe_tx_data;
  logic [NEP-1:0]    ep_sel, ep_start, ep_stop, ep_rx_valid;
  logic [7:0]        ep_rx_data;
  logic [NEP-1:0]    ep_tx_valid;
  logic [8*NEP-1:0]  ep_tx_data;
  logic [NEP-1:0]    ep_tx_ready;
  logic              busy;
  logic [7:0]        underrun_cnt, drop_cnt;

  spi_ep_router #(.NUM_EP(NEP), .IDLE_BYTE(IDLE_B)) dut (
    .clk(clk), .resetn(resetn), .spi_csel(spi_csel),
    .fe_rx_valid(fe_rx_valid), .fe_rx_data(fe_rx_data),
    .fe_tx_load(fe_tx_load), .fe_tx_data(fe_tx_data),
    .ep_sel(ep_sel), .ep_start(ep_start), .ep_stop(ep_stop),
    .ep_rx_valid(ep_rx_valid), .ep_rx_data(ep_rx_data),
    .ep_tx_valid(ep_tx_valid), .ep_tx_data(ep_tx_data), .ep_tx_ready(ep_tx_ready),
    .busy(busy), .underrun_cnt(underrun_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [NEP-1:0] v; logic [7:0] d; } ev_t;
  typedef struct { int cyc; logic busy; logic [NEP-1:0] sel, start, stop;
                   logic [7:0] under, drop; } st_t;

  ev_t rdy_q[$];
  ev_t tx_q[$];
  ev_t rx_q[$];
  st_t st_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  // Endpoint byte stores: ep_rd follows the DUT's pops, m_rd follows the model's
  logic [7:0] ep_mem [NEP][MEMN];
  int ep_wr[NEP];
  int ep_rd[NEP];
  int m_rd[NEP];
  logic [NEP-1:0] rdy_last = '0;

  int         m_mode = M_IDLE;
  int         m_sel  = 0;
  bit         m_hv   = 1'b0;
  logic [7:0] m_hd   = 8'h00;
  logic [7:0] m_under = 8'd0;
  logic [7:0] m_drop  = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NEP-1:0] oh(input int s);
    logic [NEP-1:0] r;
    r = '0;
    if (s >= 1 && s <= NEP) r[s-1] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic ep_push(input int i, input logic [7:0] b);
    if (ep_wr[i] < MEMN) begin
      ep_mem[i][ep_wr[i]] = b;
      ep_wr[i]++;
    end
  endtask

  // One clock cycle: drive inputs, predict DUT behaviour, queue expectations
  task automatic step(input int csel, input bit rxv, input logic [7:0] rxd,
                      input bit load, input logic [NEP-1:0] en);
    bit ok, act, pop;
    int k, nmode;
    logic [NEP-1:0] rdy_e, st_e, sp_e;
    ev_t e;
    st_t s;
    for (int i = 0; i < NEP; i++)
      if (rdy_last[i] && ep_rd[i] < ep_wr[i]) ep_rd[i]++;
    spi_csel    = 8'(csel);
    fe_rx_valid = rxv;
    fe_rx_data  = rxd;
    fe_tx_load  = load;
    for (int i = 0; i < NEP; i++) begin
      ep_tx_valid[i] = en[i] && (ep_rd[i] < ep_wr[i]);
      ep_tx_data[8*i +: 8] = (ep_rd[i] < ep_wr[i]) ? ep_mem[i][ep_rd[i]] : 8'($urandom);
    end

    ok  = (m_sel >= 1) && (m_sel <= NEP);
    k   = ok ? m_sel - 1 : 0;
    act = (m_mode == M_ACT) && ok;
    pop = act && !m_hv && en[k] && (m_rd[k] < ep_wr[k]);
    rdy_e = pop ? oh(m_sel) : '0;
    e.cyc = cyc; e.v = rdy_e; e.d = 8'h00;
    rdy_q.push_back(e);
    if (load) begin
      e.cyc = cyc; e.v = '0; e.d = m_hv ? m_hd : IDLE_B;
      tx_q.push_back(e);
      if (act && !m_hv) m_under = sat(m_under);
    end
    if (rxv) begin
      if (act) begin
        e.cyc = cyc + 1; e.v = oh(m_sel); e.d = rxd;
        rx_q.push_back(e);
      end else begin
        m_drop = sat(m_drop);
      end
    end

    st_e = '0; sp_e = '0; nmode = m_mode;
    case (m_mode)
      M_IDLE:  if (csel != 0) begin nmode = M_START; m_sel = csel; st_e = oh(csel); end
      M_START: nmode = M_ACT;
      M_ACT:   if (csel != m_sel) begin nmode = M_STOP; sp_e = oh(m_sel); end
      default: nmode = M_IDLE;
    endcase
    if (nmode != M_ACT) m_hv = 1'b0;
    else begin
      if (load && m_hv) m_hv = 1'b0;
      if (pop) begin m_hd = ep_mem[k][m_rd[k]]; m_hv = 1'b1; end
    end
    if (pop) m_rd[k]++;
    m_mode = nmode;

    s.cyc   = cyc + 1;
    s.busy  = (nmode != M_IDLE);
    s.sel   = (nmode == M_START || nmode == M_ACT) ? oh(m_sel) : '0;
    s.start = st_e;
    s.stop  = sp_e;
    s.under = m_under;
    s.drop  = m_drop;
    st_q.push_back(s);

    @(negedge clk);
    rdy_last = ep_tx_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int csel, input int n, input logic [NEP-1:0] en);
    for (int i = 0; i < n; i++) step(csel, 1'b0, 8'h00, 1'b0, en);
  endtask

  // Monitor: pops expectations as the DUT presents the corresponding outputs
  ev_t me;
  st_t ms;
  always @(negedge clk) begin
    if (mon_en) begin
      while (rdy_q.size() > 0 && rdy_q[0].cyc <= cyc) begin
        me = rdy_q.pop_front();
        chk("ep_tx_ready", 32'(ep_tx_ready), 32'(me.v));
      end
      while (tx_q.size() > 0 && tx_q[0].cyc <= cyc) begin
        me = tx_q.pop_front();
        chk("fe_tx_data", 32'(fe_tx_data), 32'(me.d));
      end
      while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
        ms = st_q.pop_front();
        chk("busy", 32'(busy), 32'(ms.busy));
        chk("ep_sel", 32'(ep_sel), 32'(ms.sel));
        chk("ep_start", 32'(ep_start), 32'(ms.start));
        chk("ep_stop", 32'(ep_stop), 32'(ms.stop));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(ms.under));
        chk("drop_cnt", 32'(drop_cnt), 32'(ms.drop));
      end
      if (ep_rx_valid != '0 || (rx_q.size() > 0 && rx_q[0].cyc <= cyc)) begin
        if (rx_q.size() == 0) begin
          chk("ep_rx_valid_spurious", 32'(ep_rx_valid), 32'd0);
        end else begin
          me = rx_q.pop_front();
          chk("ep_rx_valid", 32'(ep_rx_valid), 32'(me.v));
          chk("ep_rx_data", 32'(ep_rx_data), 32'(me.d));
        end
      end
    end
  end

  initial begin
    int csel, len, r;
    for (int i = 0; i < NEP; i++) begin ep_wr[i] = 0; ep_rd[i] = 0; m_rd[i] = 0; end
    resetn = 1'b0; spi_csel = 8'd0; fe_rx_valid = 1'b0; fe_rx_data = 8'd0;
    fe_tx_load = 1'b0; ep_tx_valid = '0; ep_tx_data = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ep_sel", 32'(ep_sel), 32'd0);
    chk("rst_ep_start", 32'(ep_start), 32'd0);
    chk("rst_fe_tx_data", 32'(fe_tx_data), 32'(IDLE_B));
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Select EP1, prefetch two bytes, consume them, then an rx byte
    ep_push(0, 8'h8F); ep_push(0, 8'h2A);
    idle_steps(1, 3, 4'b0000);
    step(1, 1'b0, 8'h00, 1'b1, 4'b0000);
    idle_steps(1, 2, 4'b0001);
    step(1, 1'b0, 8'h00, 1'b1, 4'b0001);
    idle_steps(1, 2, 4'b0001);
    step(1, 1'b0, 8'h00, 1'b1, 4'b0001);
    step(1, 1'b1, 8'h77, 1'b0, 4'b0001);
    // Underruns with nothing to send
    for (int i = 0; i < 3; i++) step(1, 1'b0, 8'h00, 1'b1, 4'b0000);
    // Switch 1 -> 2 -> 3 with an rx byte during STOP
    idle_steps(2, 6, 4'b0000);
    step(3, 1'b0, 8'h00, 1'b0, 4'b0000);
    step(3, 1'b1, 8'h5C, 1'b0, 4'b0000);
    idle_steps(3, 4, 4'b0000);

    // Randomized sessions across valid, null and invalid selections
    for (int s = 0; s < 30; s++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      csel = $urandom_range(1, NEP);
      else if (r < 8) csel = 0;
      else            csel = $urandom_range(NEP + 1, 12);
      len = $urandom_range(2, 25);
      for (int c = 0; c < len; c++) begin
        for (int i = 0; i < NEP; i++)
          if (ep_wr[i] - ep_rd[i] < 3 && $urandom_range(0, 1) == 1) ep_push(i, 8'($urandom));
        step(csel, $urandom_range(0, 2) == 0, 8'($urandom),
             $urandom_range(0, 2) == 0, 4'($urandom));
      end
    end

    // Underrun counter saturation
    idle_steps(1, 6, 4'b0000);
    for (int i = 0; i < 300; i++) step(1, 1'b0, 8'h00, 1'b1, 4'b0000);
    chk("underrun_saturated", 32'(underrun_cnt), 32'd255);

    // Null endpoint: rx dropped, tx idle, no underruns
    idle_steps(9, 6, 4'b1111);
    for (int i = 0; i < 4; i++) step(9, 1'b1, 8'($urandom), 1'b0, 4'b1111);
    for (int i = 0; i < 2; i++) step(9, 1'b0, 8'h00, 1'b1, 4'b1111);
    chk("null_fe_tx_data", 32'(fe_tx_data), 32'(IDLE_B));

    // Reset while EP1 is active: everything clears at once, no stop strobe
    idle_steps(1, 6, 4'b0000);
    @(negedge clk); #1;
    mon_en = 1'b0;
    chk("rx_all_delivered", 32'(rx_q.size()), 32'd0);
    chk("pre_reset_ep_sel", 32'(ep_sel), 32'b0001);
    resetn = 1'b0;
    #1;
    chk("mid_rst_ep_sel", 32'(ep_sel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ep_stop", 32'(ep_stop), 32'd0);
    chk("mid_rst_underrun", 32'(underrun_cnt), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_hold_ep_stop", 32'(ep_stop), 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
